pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the in-order core. It replaces the hard-wired stall and flush nets of the 5-stage core with one block. The block keeps a per-stage scoreboard of in-flight destination registers and detects load-use hazards, which the current core cannot do. It arbitrates memory stall, jump flush and hazard interlock, and emits per-stage hold, kill and bubble controls plus saturating performance counters. It sits beside the stages; each stage consumes one bit of each mask.

---
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the in-order core: load-use scoreboard, freeze/flush/interlock
// arbitration, per-stage stall/kill masks and saturating performance counters.
module pipe_ctrl #(
  parameter int STAGES     = 5,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mem_wait,
  input  logic                  jump,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_wr,
  input  logic                  id_is_load,
  input  logic                  cnt_clr,
  output logic [STAGES-1:0]     stall,
  output logic [STAGES-1:0]     kill,
  output logic                  ex_bubble,
  output logic [STAGES-1:0]     sb_valid,
  output logic [CNT_W-1:0]      cnt_retired,
  output logic [CNT_W-1:0]      cnt_mem_stall,
  output logic [CNT_W-1:0]      cnt_hzd_stall,
  output logic [CNT_W-1:0]      cnt_flush
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [STAGES-1:2]     vld_q, vld_d;
  logic [STAGES-1:2]     wr_q, wr_d;
  logic [STAGES-1:2]     ld_q, ld_d;
  logic [REG_ADDR_W-1:0] rd_q [2:STAGES-1];
  logic [REG_ADDR_W-1:0] rd_d [2:STAGES-1];

  logic [CNT_W-1:0] cnt_retired_q, cnt_retired_d;
  logic [CNT_W-1:0] cnt_mem_stall_q, cnt_mem_stall_d;
  logic [CNT_W-1:0] cnt_hzd_stall_q, cnt_hzd_stall_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

  logic freeze;
  logic hazard;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    return (inc && (cnt != '1)) ? cnt + CNT_ONE : cnt;
  endfunction

  assign freeze = !en || mem_wait;

  // Load-use detection: only loads still inside the non-forwardable window count
  always_comb begin
    hazard = 1'b0;
    for (int s = 2; s < 2 + LOAD_LAT; s++) begin
      if (vld_q[s] && wr_q[s] && ld_q[s] && (rd_q[s] != '0) &&
          ((id_rs1_used && (id_rs1 == rd_q[s])) || (id_rs2_used && (id_rs2 == rd_q[s]))))
        hazard = 1'b1;
    end
    hazard = hazard && id_valid;
  end

  always_comb begin
    stall     = '0;
    kill      = '0;
    ex_bubble = 1'b0;
    if (freeze) begin
      stall = '1;
    end else if (jump) begin
      kill[1:0] = 2'b11;
      ex_bubble = 1'b1;
    end else if (hazard) begin
      stall[1:0] = 2'b11;
      ex_bubble  = 1'b1;
    end
  end

  always_comb begin
    vld_d = vld_q;
    wr_d  = wr_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    if (!freeze) begin
      vld_d[2] = id_valid && !jump && !hazard;
      wr_d[2]  = id_reg_wr;
      ld_d[2]  = id_is_load;
      rd_d[2]  = id_rd;
      for (int s = 3; s < STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        wr_d[s]  = wr_q[s-1];
        ld_d[s]  = ld_q[s-1];
        rd_d[s]  = rd_q[s-1];
      end
    end
  end

  always_comb begin
    if (cnt_clr) begin
      cnt_retired_d   = '0;
      cnt_mem_stall_d = '0;
      cnt_hzd_stall_d = '0;
      cnt_flush_d     = '0;
    end else begin
      cnt_retired_d   = sat_inc(cnt_retired_q, vld_q[STAGES-1] && !freeze);
      cnt_mem_stall_d = sat_inc(cnt_mem_stall_q, en && mem_wait);
      cnt_hzd_stall_d = sat_inc(cnt_hzd_stall_q, hazard && !jump && !freeze);
      cnt_flush_d     = sat_inc(cnt_flush_q, jump && !freeze);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q           <= '0;
      cnt_retired_q   <= '0;
      cnt_mem_stall_q <= '0;
      cnt_hzd_stall_q <= '0;
      cnt_flush_q     <= '0;
    end else begin
      vld_q           <= vld_d;
      cnt_retired_q   <= cnt_retired_d;
      cnt_mem_stall_q <= cnt_mem_stall_d;
      cnt_hzd_stall_q <= cnt_hzd_stall_d;
      cnt_flush_q     <= cnt_flush_d;
    end
  end

  // Entry payload is only meaningful while its valid bit is set, so it carries no reset
  always_ff @(posedge clk) begin
    wr_q <= wr_d;
    ld_q <= ld_d;
    rd_q <= rd_d;
  end

  assign sb_valid      = {vld_q, 2'b00};
  assign cnt_retired   = cnt_retired_q;
  assign cnt_mem_stall = cnt_mem_stall_q;
  assign cnt_hzd_stall = cnt_hzd_stall_q;
  assign cnt_flush     = cnt_flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: an instruction-level pipeline model checked every
// cycle, plus directed load-use, jump, mem_wait, saturation and reset scenarios.
module tb_pipe_ctrl;
  localparam int STAGES = 6;
  localparam int RW     = 5;
  localparam int LL     = 2;
  localparam int CW     = 4;
  localparam int CAP    = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en, mem_wait, jump, id_valid;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic id_rs1_used, id_rs2_used, id_reg_wr, id_is_load, cnt_clr;
  logic [STAGES-1:0] stall, kill, sb_valid;
  logic ex_bubble;
  logic [CW-1:0] cnt_retired, cnt_mem_stall, cnt_hzd_stall, cnt_flush;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(STAGES), .REG_ADDR_W(RW), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mem_wait(mem_wait), .jump(jump),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .cnt_clr(cnt_clr),
    .stall(stall), .kill(kill), .ex_bubble(ex_bubble), .sb_valid(sb_valid),
    .cnt_retired(cnt_retired), .cnt_mem_stall(cnt_mem_stall),
    .cnt_hzd_stall(cnt_hzd_stall), .cnt_flush(cnt_flush));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what instruction sits in each post-ID stage
  typedef struct packed {
    bit          v;
    logic [RW-1:0] rd;
    bit          wr;
    bit          ld;
  } instr_t;

  instr_t pipe [STAGES];
  int m_ret = 0, m_mem = 0, m_hzd = 0, m_fl = 0;

  function automatic bit m_hazard();
    if (!id_valid) return 1'b0;
    for (int age = 0; age < LL; age++) begin
      instr_t p;
      p = pipe[2 + age];
      if (p.v && p.wr && p.ld && p.rd != 0 &&
          ((id_rs1_used && id_rs1 == p.rd) || (id_rs2_used && id_rs2 == p.rd)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int sat(input int c);
    return (c < CAP) ? c + 1 : c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit fr, hz;
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) pipe[s] = '0;
      m_ret = 0; m_mem = 0; m_hzd = 0; m_fl = 0;
    end else begin
      fr = !en || mem_wait;
      hz = m_hazard();
      if (cnt_clr) begin
        m_ret = 0; m_mem = 0; m_hzd = 0; m_fl = 0;
      end else begin
        if (pipe[STAGES-1].v && !fr) m_ret = sat(m_ret);
        if (en && mem_wait)          m_mem = sat(m_mem);
        if (hz && !jump && !fr)      m_hzd = sat(m_hzd);
        if (jump && !fr)             m_fl  = sat(m_fl);
      end
      if (!fr) begin
        for (int s = STAGES - 1; s > 2; s--) pipe[s] = pipe[s-1];
        pipe[2].v  = id_valid && !jump && !hz;
        pipe[2].rd = id_rd;
        pipe[2].wr = id_reg_wr;
        pipe[2].ld = id_is_load;
      end
    end
  end

  always @(negedge clk) begin
    bit fr, hz, eb;
    logic [STAGES-1:0] es, ek, esb;
    fr = !en || mem_wait;
    hz = m_hazard();
    es = '0; ek = '0; eb = 1'b0;
    if (fr) es = '1;
    else if (jump) begin ek = STAGES'(3); eb = 1'b1; end
    else if (hz) begin es = STAGES'(3); eb = 1'b1; end
    esb = '0;
    for (int s = 2; s < STAGES; s++) esb[s] = pipe[s].v;
    chk("stall", stall, es);
    chk("kill", kill, ek);
    chk("ex_bubble", ex_bubble, eb);
    chk("sb_valid", sb_valid, esb);
    chk("cnt_retired", cnt_retired, m_ret);
    chk("cnt_mem_stall", cnt_mem_stall, m_mem);
    chk("cnt_hzd_stall", cnt_hzd_stall, m_hzd);
    chk("cnt_flush", cnt_flush, m_fl);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wr, input bit ld);
    id_valid = v; id_rs1 = RW'(rs1); id_rs1_used = u1; id_rs2 = RW'(rs2); id_rs2_used = u2;
    id_rd = RW'(rd); id_reg_wr = wr; id_is_load = ld;
  endtask

  task automatic idle();
    en = 1'b1; mem_wait = 1'b0; jump = 1'b0; cnt_clr = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (STAGES) step();
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  // Hold the current ID inputs until the interlock releases; returns hazard cycles seen
  task automatic count_hz(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stall[1]) begin
        n++;
        chk("hz_stall_lit", stall, STAGES'(3));
        step();
      end else begin
        break;
      end
    end
  endtask

  initial begin
    int n;
    idle();
    #2;
    chk("reset_sb_valid", sb_valid, 0);
    chk("reset_cnt_retired", cnt_retired, 0);
    repeat (2) step();
    rst_n = 1'b1;

    // Back-to-back load-use: LOAD_LAT cycles
    clr();
    set_id(1, 0, 0, 0, 0, 7, 1, 1); step();
    set_id(1, 0, 0, 7, 1, 1, 1, 0);
    count_hz(n);
    chk("b2b_cycles", n, 2);
    chk("b2b_cnt_hzd", cnt_hzd_stall, 2);
    step(); drain();

    // One independent instruction in between: one cycle
    set_id(1, 0, 0, 0, 0, 7, 1, 1); step();
    set_id(1, 2, 1, 0, 0, 2, 1, 0); step();
    set_id(1, 7, 1, 0, 0, 3, 1, 0);
    count_hz(n);
    chk("dist2_cycles", n, 1);
    step(); drain();

    // r0 and unused source never interlock
    set_id(1, 0, 0, 0, 0, 0, 1, 1); step();
    set_id(1, 0, 1, 0, 1, 4, 1, 0);
    count_hz(n);
    chk("r0_cycles", n, 0);
    step(); drain();
    set_id(1, 0, 0, 0, 0, 7, 1, 1); step();
    set_id(1, 0, 0, 7, 0, 4, 1, 0);
    count_hz(n);
    chk("unused_cycles", n, 0);
    step(); drain();

    // Jump wins over a hazard in the same cycle
    clr();
    set_id(1, 0, 0, 0, 0, 7, 1, 1); step();
    set_id(1, 7, 1, 0, 0, 5, 1, 0); jump = 1'b1;
    @(negedge clk);
    chk("jh_kill", kill, 3);
    chk("jh_stall", stall, 0);
    chk("jh_bubble", ex_bubble, 1);
    step(); idle();
    @(negedge clk);
    chk("jh_cnt_flush", cnt_flush, 1);
    chk("jh_cnt_hzd", cnt_hzd_stall, 0);
    drain();

    // mem_wait freezes a pending hazard
    clr();
    set_id(1, 0, 0, 0, 0, 7, 1, 1); step();
    set_id(1, 7, 1, 0, 0, 5, 1, 0);
    @(negedge clk);
    chk("mw_first_hz", stall, 3);
    step();
    mem_wait = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mw_stall_all", stall, {STAGES{1'b1}});
      step();
    end
    mem_wait = 1'b0;
    count_hz(n);
    chk("mw_remaining", n, 1);
    chk("mw_cnt_mem", cnt_mem_stall, 3);
    step(); drain();

    // Saturation of cnt_retired, and clear beating increment
    clr();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    repeat (20) step();
    idle();
    repeat (STAGES) step();
    @(negedge clk);
    chk("sat_retired", cnt_retired, 15);
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    repeat (STAGES) step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_over_inc", cnt_retired, 0);

    // Asynchronous reset mid-stream with the scoreboard full
    set_id(1, 0, 0, 0, 0, 6, 1, 1);
    repeat (STAGES + 2) step();
    @(negedge clk);
    chk("pre_rst_sb_full", sb_valid, {{(STAGES-2){1'b1}}, 2'b00});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sb", sb_valid, 0);
    chk("async_rst_ret", cnt_retired, 0);
    chk("async_rst_hzd", cnt_hzd_stall, 0);
    step();
    rst_n = 1'b1;
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en          = ($urandom_range(0, 9) != 0);
      mem_wait    = ($urandom_range(0, 9) == 0);
      jump        = ($urandom_range(0, 9) == 0);
      cnt_clr     = ($urandom_range(0, 49) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = RW'($urandom_range(0, 3));
      id_rs2      = RW'($urandom_range(0, 3));
      id_rd       = RW'($urandom_range(0, 3));
      id_rs1_used = $urandom_range(0, 1) != 0;
      id_rs2_used = $urandom_range(0, 1) != 0;
      id_reg_wr   = ($urandom_range(0, 3) != 0);
      id_is_load  = $urandom_range(0, 1) != 0;
      rst_n       = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
